bus_arb2: RTL and testbench
===========================

// Module: bus_arb2
// PURPOSE
//  2-master -> 1-slave arbiter on bus_trans_if; sits between two masters (e.g. ifetch, lsu)
//  and one shared slave port. Round-robin grants requests, records issuing master per
//  accepted request in an order FIFO, routes in-order responses back to that master.
//  Zero-latency on both paths (combinational forward); registered state only.
// PARAMETERS
//  BTI_AW     32  address width, passed to all bus_trans_if ports
//  BTI_DW     32  data width, passed to all bus_trans_if ports
//  OST_DEPTH   4  max outstanding requests (order FIFO depth, power of 2, >=2)
// PORTS
//  clk  input   1       clock, all state on rising edge
//  rst  input   1       asynchronous reset, active-high
//  m0   bus_trans_if.slave   BTI_AW/BTI_DW  master 0 side (higher priority on tie at reset)
//  m1   bus_trans_if.slave   BTI_AW/BTI_DW  master 1 side
//  s    bus_trans_if.master  BTI_AW/BTI_DW  downstream slave side
// BEHAVIOUR
//  - Reset (rst high): FIFO empty, cnt=0, rr_ptr=m0, lock=0; s.req_vld, s.rsp_rdy,
//    m0/m1.req_rdy, m0/m1.rsp_vld forced 0. req_pkt/rsp_pkt outputs don't-care.
//  - State: rr_ptr (1b, master preferred next), lock (1b) + lock_id (1b),
//    order FIFO of OST_DEPTH x 1b master ids, cnt 0..OST_DEPTH.
//  - Grant: if lock, gnt=lock_id; else if one master vld, that one; if both, gnt=rr_ptr.
//  - full = (cnt==OST_DEPTH). s.req_vld = gnt_master.req_vld & ~full;
//    s.req_pkt = gnt_master.req_pkt (cmd/addr/data/strobe unchanged);
//    gnt_master.req_rdy = s.req_rdy & ~full; other master req_rdy=0.
//  - Lock: s.req_vld & ~s.req_rdy -> lock=1, lock_id=gnt next cycle; cleared on the
//    s.req handshake. Grant never switches while a presented request is unaccepted.
//  - On s.req handshake: push gnt id, rr_ptr <= ~gnt (RR mode).
//  - Full: s.req_vld held 0, no lock set; arbitration resumes when cnt<OST_DEPTH.
//    Same-cycle pop while full does NOT free a push slot (full from registered cnt).
//  - Response: head = FIFO head id. head master rsp_vld = s.rsp_vld & ~empty,
//    rsp_pkt = s.rsp_pkt; other master rsp_vld=0. s.rsp_rdy = head.rsp_rdy & ~empty.
//  - On s.rsp handshake: pop. Push+pop same cycle: cnt unchanged, both pointers advance.
//  - s.rsp_vld with FIFO empty: protocol error, s.rsp_rdy=0 (response stalls, not lost).
//  - Slave must return responses in request order; arbiter does no reordering.
//  - Pointers wrap modulo OST_DEPTH; cnt saturation impossible by full gating.
//  - rst mid-transaction: all outstanding ids discarded; caller resets slave too.
// CONFIGURATION
//  BUS_ARB_FIXED_PRIO_EN defined: m0 strict priority, rr_ptr unused (constant m0);
//    lock behaviour unchanged. m1 may starve.
//  Not defined: round-robin as above; neither master starves under continuous requests.
// TESTING
//  1. m0 only, addr 0x100, s.req_rdy=1 -> s.req_vld same cycle, addr 0x100; rsp data
//     0xDEADBEEF ok=1 returns on m0 only, m1.rsp_vld=0.
//  2. m0,m1 both vld every cycle, slave always ready -> grants alternate m0,m1,m0,m1
//     from reset; with BUS_ARB_FIXED_PRIO_EN -> m0 every cycle.
//  3. m1 granted, s.req_rdy=0 for 3 cycles while m0 also vld -> s.req_pkt stays m1's,
//     m0.req_rdy=0 throughout; m1 accepted cycle 4, then m0.
//  4. 4 requests accepted (OST_DEPTH=4), no rsp -> 5th: s.req_vld=0, req_rdy=0; one rsp
//     pop -> 5th issues next cycle, not same cycle.
//  5. Issue m0,m1,m0 then 3 responses d=1,2,3 -> m0 gets 1, m1 gets 2, m0 gets 3;
//     m1.rsp_rdy=0 on 2nd rsp stalls s.rsp_rdy until asserted.
//  6. Assert rst with 2 outstanding -> all vld/rdy outputs 0 immediately; after release
//     cnt=0, first tie grants m0.

Source files
------------

// File: rtl/bus_arb2.sv
// bus_arb2: two-master to one-slave request arbiter with in-order response routing.
// Define BUS_ARB_FIXED_PRIO_EN for strict m0 priority instead of round-robin.
module bus_arb2 #(
    parameter int unsigned BTI_AW    = 32,
    parameter int unsigned BTI_DW    = 32,
    parameter int unsigned OST_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req_vld,
    output logic                  m0_req_rdy,
    input  logic                  m0_req_cmd,
    input  logic [BTI_AW-1:0]     m0_req_addr,
    input  logic [BTI_DW-1:0]     m0_req_data,
    input  logic [BTI_DW/8-1:0]   m0_req_strb,
    output logic                  m0_rsp_vld,
    input  logic                  m0_rsp_rdy,
    output logic [BTI_DW-1:0]     m0_rsp_data,
    output logic                  m0_rsp_ok,

    input  logic                  m1_req_vld,
    output logic                  m1_req_rdy,
    input  logic                  m1_req_cmd,
    input  logic [BTI_AW-1:0]     m1_req_addr,
    input  logic [BTI_DW-1:0]     m1_req_data,
    input  logic [BTI_DW/8-1:0]   m1_req_strb,
    output logic                  m1_rsp_vld,
    input  logic                  m1_rsp_rdy,
    output logic [BTI_DW-1:0]     m1_rsp_data,
    output logic                  m1_rsp_ok,

    output logic                  s_req_vld,
    input  logic                  s_req_rdy,
    output logic                  s_req_cmd,
    output logic [BTI_AW-1:0]     s_req_addr,
    output logic [BTI_DW-1:0]     s_req_data,
    output logic [BTI_DW/8-1:0]   s_req_strb,
    input  logic                  s_rsp_vld,
    output logic                  s_rsp_rdy,
    input  logic [BTI_DW-1:0]     s_rsp_data,
    input  logic                  s_rsp_ok
);

    localparam int unsigned PW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int unsigned CW = $clog2(OST_DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OST_DEPTH);

    typedef enum logic {
        MST_0 = 1'b0,
        MST_1 = 1'b1
    } mst_e;

    mst_e           gnt;
    mst_e           pref;
    mst_e           lock_id;
    mst_e           head;
    logic           lock;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    mst_e           fifo [OST_DEPTH];
    logic           full;
    logic           empty;
    logic           gnt_vld;
    logic           req_hs;
    logic           rsp_hs;

`ifdef BUS_ARB_FIXED_PRIO_EN
    assign pref = MST_0;
`else
    mst_e rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= MST_0;
        end else if (req_hs) begin
            rr_ptr <= (gnt == MST_0) ? MST_1 : MST_0;
        end
    end

    assign pref = rr_ptr;
`endif

    // A presented but unaccepted request pins the grant until its handshake.
    always_comb begin
        gnt = pref;
        if (lock) begin
            gnt = lock_id;
        end else if (m0_req_vld && !m1_req_vld) begin
            gnt = MST_0;
        end else if (m1_req_vld && !m0_req_vld) begin
            gnt = MST_1;
        end
    end

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign gnt_vld = (gnt == MST_1) ? m1_req_vld : m0_req_vld;

    always_comb begin
        s_req_vld  = gnt_vld & ~full & ~rst;
        s_req_cmd  = m0_req_cmd;
        s_req_addr = m0_req_addr;
        s_req_data = m0_req_data;
        s_req_strb = m0_req_strb;
        if (gnt == MST_1) begin
            s_req_cmd  = m1_req_cmd;
            s_req_addr = m1_req_addr;
            s_req_data = m1_req_data;
            s_req_strb = m1_req_strb;
        end
        m0_req_rdy = (gnt == MST_0) & s_req_rdy & ~full & ~rst;
        m1_req_rdy = (gnt == MST_1) & s_req_rdy & ~full & ~rst;
    end

    assign req_hs = s_req_vld & s_req_rdy;
    assign head   = fifo[rd_ptr];

    // An empty order FIFO blocks the response path so a stray response stalls.
    always_comb begin
        s_rsp_rdy   = ~empty & ~rst & ((head == MST_1) ? m1_rsp_rdy : m0_rsp_rdy);
        m0_rsp_vld  = s_rsp_vld & ~empty & ~rst & (head == MST_0);
        m1_rsp_vld  = s_rsp_vld & ~empty & ~rst & (head == MST_1);
        m0_rsp_data = s_rsp_data;
        m1_rsp_data = s_rsp_data;
        m0_rsp_ok   = s_rsp_ok;
        m1_rsp_ok   = s_rsp_ok;
    end

    assign rsp_hs = s_rsp_vld & s_rsp_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock    <= 1'b0;
            lock_id <= MST_0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
        end else begin
            if (req_hs) begin
                lock <= 1'b0;
            end else if (s_req_vld && !s_req_rdy) begin
                lock    <= 1'b1;
                lock_id <= gnt;
            end
            if (req_hs) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rsp_hs) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({req_hs, rsp_hs})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) begin
            fifo[wr_ptr] <= gnt;
        end
    end

endmodule

// File: tb/tb_bus_arb2.sv
// tb_bus_arb2: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_bus_arb2;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          m0_req_vld, m0_req_rdy, m0_req_cmd;
    logic [AW-1:0] m0_req_addr;
    logic [DW-1:0] m0_req_data;
    logic [SW-1:0] m0_req_strb;
    logic          m0_rsp_vld, m0_rsp_rdy, m0_rsp_ok;
    logic [DW-1:0] m0_rsp_data;
    logic          m1_req_vld, m1_req_rdy, m1_req_cmd;
    logic [AW-1:0] m1_req_addr;
    logic [DW-1:0] m1_req_data;
    logic [SW-1:0] m1_req_strb;
    logic          m1_rsp_vld, m1_rsp_rdy, m1_rsp_ok;
    logic [DW-1:0] m1_rsp_data;
    logic          s_req_vld, s_req_rdy, s_req_cmd;
    logic [AW-1:0] s_req_addr;
    logic [DW-1:0] s_req_data;
    logic [SW-1:0] s_req_strb;
    logic          s_rsp_vld, s_rsp_rdy, s_rsp_ok;
    logic [DW-1:0] s_rsp_data;

    int errors = 0;
    int checks = 0;

    bus_arb2 #(.BTI_AW(AW), .BTI_DW(DW), .OST_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m0_req_vld(m0_req_vld), .m0_req_rdy(m0_req_rdy), .m0_req_cmd(m0_req_cmd),
        .m0_req_addr(m0_req_addr), .m0_req_data(m0_req_data), .m0_req_strb(m0_req_strb),
        .m0_rsp_vld(m0_rsp_vld), .m0_rsp_rdy(m0_rsp_rdy), .m0_rsp_data(m0_rsp_data),
        .m0_rsp_ok(m0_rsp_ok),
        .m1_req_vld(m1_req_vld), .m1_req_rdy(m1_req_rdy), .m1_req_cmd(m1_req_cmd),
        .m1_req_addr(m1_req_addr), .m1_req_data(m1_req_data), .m1_req_strb(m1_req_strb),
        .m1_rsp_vld(m1_rsp_vld), .m1_rsp_rdy(m1_rsp_rdy), .m1_rsp_data(m1_rsp_data),
        .m1_rsp_ok(m1_rsp_ok),
        .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_req_cmd(s_req_cmd),
        .s_req_addr(s_req_addr), .s_req_data(s_req_data), .s_req_strb(s_req_strb),
        .s_rsp_vld(s_rsp_vld), .s_rsp_rdy(s_rsp_rdy), .s_rsp_data(s_rsp_data),
        .s_rsp_ok(s_rsp_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        m0_req_vld = 1'b0; m0_req_cmd = 1'b0; m0_req_addr = '0; m0_req_data = '0;
        m0_req_strb = '1; m0_rsp_rdy = 1'b0;
        m1_req_vld = 1'b0; m1_req_cmd = 1'b0; m1_req_addr = '0; m1_req_data = '0;
        m1_req_strb = '1; m1_rsp_rdy = 1'b0;
        s_req_rdy = 1'b0; s_rsp_vld = 1'b0; s_rsp_data = '0; s_rsp_ok = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_idle();
        #1;
        m0_req_vld = 1'b1; m1_req_vld = 1'b1; s_req_rdy = 1'b1;
        s_rsp_vld = 1'b1; m0_rsp_rdy = 1'b1; m1_rsp_rdy = 1'b1;
        rst = 1'b1;
        #1;
        if ({s_req_vld, s_rsp_rdy, m0_req_rdy, m1_req_rdy, m0_rsp_vld, m1_rsp_vld} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {s_req_vld, s_rsp_rdy, m0_req_rdy, m1_req_rdy, m0_rsp_vld, m1_rsp_vld});
        end
        checks++;
        tick();
        tick();
        rst = 1'b0;
        m0_req_vld = 1'b0; m1_req_vld = 1'b0;
        #1;
        if (s_rsp_rdy !== 1'b0) begin
            errors++; $display("FAIL empty_rsp_rdy: got %b expected 0", s_rsp_rdy);
        end
        checks++;
        if ({m0_rsp_vld, m1_rsp_vld} !== 2'b00) begin
            errors++; $display("FAIL empty_rsp_vld: got %b expected 00", {m0_rsp_vld, m1_rsp_vld});
        end
        checks++;
        tick();
        set_idle();
    endtask

    task automatic test_single();
        do_reset();
        m0_req_vld = 1'b1; m0_req_addr = 32'h100; m0_req_data = 32'h55; m0_req_cmd = 1'b1;
        s_req_rdy = 1'b1;
        #1;
        if (s_req_vld !== 1'b1 || s_req_addr !== 32'h100 || s_req_data !== 32'h55 || s_req_cmd !== 1'b1) begin
            errors++;
            $display("FAIL single_req: got vld=%b addr=%0h data=%0h cmd=%b expected vld=1 addr=100 data=55 cmd=1",
                     s_req_vld, s_req_addr, s_req_data, s_req_cmd);
        end
        checks++;
        if ({m0_req_rdy, m1_req_rdy} !== 2'b10) begin
            errors++; $display("FAIL single_req_rdy: got %b expected 10", {m0_req_rdy, m1_req_rdy});
        end
        checks++;
        tick();
        m0_req_vld = 1'b0; s_req_rdy = 1'b0;
        s_rsp_vld = 1'b1; s_rsp_data = 32'hDEADBEEF; s_rsp_ok = 1'b1;
        m0_rsp_rdy = 1'b1; m1_rsp_rdy = 1'b1;
        #1;
        if (m0_rsp_vld !== 1'b1 || m0_rsp_data !== 32'hDEADBEEF || m0_rsp_ok !== 1'b1) begin
            errors++;
            $display("FAIL single_rsp_m0: got vld=%b data=%0h ok=%b expected vld=1 data=deadbeef ok=1",
                     m0_rsp_vld, m0_rsp_data, m0_rsp_ok);
        end
        checks++;
        if (m1_rsp_vld !== 1'b0 || s_rsp_rdy !== 1'b1) begin
            errors++;
            $display("FAIL single_rsp_route: got m1_vld=%b s_rdy=%b expected 0 1", m1_rsp_vld, s_rsp_rdy);
        end
        checks++;
        tick();
        set_idle();
    endtask

    task automatic test_alternate();
        int exp_g;
        do_reset();
        m0_req_vld = 1'b1; m0_req_addr = 32'h1000;
        m1_req_vld = 1'b1; m1_req_addr = 32'h2000;
        s_req_rdy = 1'b1; s_rsp_vld = 1'b1; m0_rsp_rdy = 1'b1; m1_rsp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            #1;
            if (s_req_vld !== 1'b1 || s_req_addr !== ((exp_g == 0) ? 32'h1000 : 32'h2000)) begin
                errors++;
                $display("FAIL alternate_grant i=%0d: got vld=%b addr=%0h expected master %0d",
                         i, s_req_vld, s_req_addr, exp_g);
            end
            checks++;
            if ({m1_req_rdy, m0_req_rdy} !== ((exp_g == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL alternate_rdy i=%0d: got %b expected master %0d only",
                         i, {m1_req_rdy, m0_req_rdy}, exp_g);
            end
            checks++;
            tick();
        end
        set_idle();
    endtask

    task automatic test_lock();
        do_reset();
        m1_req_vld = 1'b1; m1_req_addr = 32'hB000;
        m0_req_addr = 32'hA000;
        s_req_rdy = 1'b0;
        tick();
        m0_req_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (s_req_vld !== 1'b1 || s_req_addr !== 32'hB000 || m0_req_rdy !== 1'b0) begin
                errors++;
                $display("FAIL lock_hold i=%0d: got vld=%b addr=%0h m0_rdy=%b expected 1 b000 0",
                         i, s_req_vld, s_req_addr, m0_req_rdy);
            end
            checks++;
            tick();
        end
        s_req_rdy = 1'b1;
        #1;
        if (s_req_addr !== 32'hB000 || m1_req_rdy !== 1'b1 || m0_req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: got addr=%0h m1_rdy=%b m0_rdy=%b expected b000 1 0",
                     s_req_addr, m1_req_rdy, m0_req_rdy);
        end
        checks++;
        tick();
        m1_req_vld = 1'b0;
        #1;
        if (s_req_vld !== 1'b1 || s_req_addr !== 32'hA000 || m0_req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL lock_next_m0: got vld=%b addr=%0h m0_rdy=%b expected 1 a000 1",
                     s_req_vld, s_req_addr, m0_req_rdy);
        end
        checks++;
        tick();
        set_idle();
    endtask

    task automatic test_full();
        do_reset();
        s_req_rdy = 1'b1;
        m0_req_vld = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            m0_req_addr = 32'h400 + 32'(i);
            #1;
            if (m0_req_rdy !== 1'b1) begin
                errors++; $display("FAIL full_fill i=%0d: got rdy=%b expected 1", i, m0_req_rdy);
            end
            checks++;
            tick();
        end
        m0_req_addr = 32'h500;
        #1;
        if (s_req_vld !== 1'b0 || m0_req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL full_block: got vld=%b rdy=%b expected 0 0", s_req_vld, m0_req_rdy);
        end
        checks++;
        tick();
        s_rsp_vld = 1'b1; s_rsp_data = 32'h400; m0_rsp_rdy = 1'b1;
        #1;
        if (s_req_vld !== 1'b0 || s_rsp_rdy !== 1'b1 || m0_rsp_vld !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_same_cycle: got s_req_vld=%b s_rsp_rdy=%b m0_rsp_vld=%b expected 0 1 1",
                     s_req_vld, s_rsp_rdy, m0_rsp_vld);
        end
        checks++;
        tick();
        s_rsp_vld = 1'b0;
        #1;
        if (s_req_vld !== 1'b1 || s_req_addr !== 32'h500 || m0_req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL full_resume: got vld=%b addr=%0h rdy=%b expected 1 500 1",
                     s_req_vld, s_req_addr, m0_req_rdy);
        end
        checks++;
        tick();
        set_idle();
    endtask

    task automatic test_rsp_route();
        do_reset();
        s_req_rdy = 1'b1;
        m0_req_vld = 1'b1; m0_req_addr = 32'h10;
        tick();
        m0_req_vld = 1'b0; m1_req_vld = 1'b1; m1_req_addr = 32'h20;
        tick();
        m1_req_vld = 1'b0; m0_req_vld = 1'b1; m0_req_addr = 32'h30;
        tick();
        m0_req_vld = 1'b0; s_req_rdy = 1'b0;
        m0_rsp_rdy = 1'b1; m1_rsp_rdy = 1'b1;
        s_rsp_vld = 1'b1; s_rsp_data = 32'd1;
        #1;
        if ({m0_rsp_vld, m1_rsp_vld} !== 2'b10 || m0_rsp_data !== 32'd1 || s_rsp_rdy !== 1'b1) begin
            errors++;
            $display("FAIL route_rsp1: got vld=%b data=%0d s_rdy=%b expected 10 1 1",
                     {m0_rsp_vld, m1_rsp_vld}, m0_rsp_data, s_rsp_rdy);
        end
        checks++;
        tick();
        s_rsp_data = 32'd2; m1_rsp_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if ({m0_rsp_vld, m1_rsp_vld} !== 2'b01 || s_rsp_rdy !== 1'b0) begin
                errors++;
                $display("FAIL route_rsp2_stall i=%0d: got vld=%b s_rdy=%b expected 01 0",
                         i, {m0_rsp_vld, m1_rsp_vld}, s_rsp_rdy);
            end
            checks++;
            tick();
        end
        m1_rsp_rdy = 1'b1;
        #1;
        if (m1_rsp_vld !== 1'b1 || m1_rsp_data !== 32'd2 || s_rsp_rdy !== 1'b1) begin
            errors++;
            $display("FAIL route_rsp2: got vld=%b data=%0d s_rdy=%b expected 1 2 1",
                     m1_rsp_vld, m1_rsp_data, s_rsp_rdy);
        end
        checks++;
        tick();
        s_rsp_data = 32'd3;
        #1;
        if ({m0_rsp_vld, m1_rsp_vld} !== 2'b10 || m0_rsp_data !== 32'd3) begin
            errors++;
            $display("FAIL route_rsp3: got vld=%b data=%0d expected 10 3",
                     {m0_rsp_vld, m1_rsp_vld}, m0_rsp_data);
        end
        checks++;
        tick();
        #1;
        if (s_rsp_rdy !== 1'b0 || {m0_rsp_vld, m1_rsp_vld} !== 2'b00) begin
            errors++;
            $display("FAIL route_stray_rsp: got s_rdy=%b vld=%b expected 0 00",
                     s_rsp_rdy, {m0_rsp_vld, m1_rsp_vld});
        end
        checks++;
        tick();
        set_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_req_rdy = 1'b1;
        m0_req_vld = 1'b1; m0_req_addr = 32'hC0;
        tick();
        m0_req_vld = 1'b0; m1_req_vld = 1'b1; m1_req_addr = 32'hD0;
        tick();
        m0_req_vld = 1'b1;
        s_rsp_vld = 1'b1; m0_rsp_rdy = 1'b1; m1_rsp_rdy = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        if ({s_req_vld, s_rsp_rdy, m0_req_rdy, m1_req_rdy, m0_rsp_vld, m1_rsp_vld} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 000000",
                     {s_req_vld, s_rsp_rdy, m0_req_rdy, m1_req_rdy, m0_rsp_vld, m1_rsp_vld});
        end
        checks++;
        tick();
        rst = 1'b0;
        #1;
        if (s_rsp_rdy !== 1'b0 || {m0_rsp_vld, m1_rsp_vld} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_empty: got s_rdy=%b vld=%b expected 0 00",
                     s_rsp_rdy, {m0_rsp_vld, m1_rsp_vld});
        end
        checks++;
        if (s_req_vld !== 1'b1 || s_req_addr !== 32'hC0 || {m1_req_rdy, m0_req_rdy} !== 2'b01) begin
            errors++;
            $display("FAIL midreset_tie_m0: got vld=%b addr=%0h rdy=%b expected 1 c0 01",
                     s_req_vld, s_req_addr, {m1_req_rdy, m0_req_rdy});
        end
        checks++;
        tick();
        set_idle();
    endtask

    task automatic test_random();
        int            ost[$];
        logic [DW-1:0] slv[$];
        logic [DW-1:0] eq0[$];
        logic [DW-1:0] eq1[$];
        bit            mv [2];
        logic [AW-1:0] ma [2];
        logic [DW-1:0] md [2];
        logic          mc [2];
        logic [SW-1:0] ms [2];
        bit            rr [2];
        bit            sv;
        logic [DW-1:0] sdat;
        logic          sok;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] obs_d;
        logic          obs_ok;
        int            pref, held, g, h;
        bit            full, exp_svld, exp_srr, req_hs, rsp_hs, obs_rdy;
        logic [DW-1:0] tag;

        do_reset();
        pref = 0; held = -1; sv = 0; tag = 32'h1000; sdat = '0; sok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; ma[i] = '0; md[i] = '0; mc[i] = 1'b0; ms[i] = '0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!mv[i] && ($urandom % 3 != 0)) begin
                    mv[i] = 1; ma[i] = $urandom; md[i] = tag; mc[i] = 1'($urandom);
                    ms[i] = SW'($urandom); tag = tag + 1;
                end
                rr[i] = ($urandom % 4 != 0);
            end
            if (!sv && slv.size() > 0 && ($urandom % 2 == 0)) begin
                sv = 1; sdat = slv[0]; sok = 1'($urandom);
            end
            m0_req_vld = mv[0]; m0_req_addr = ma[0]; m0_req_data = md[0];
            m0_req_cmd = mc[0]; m0_req_strb = ms[0]; m0_rsp_rdy = rr[0];
            m1_req_vld = mv[1]; m1_req_addr = ma[1]; m1_req_data = md[1];
            m1_req_cmd = mc[1]; m1_req_strb = ms[1]; m1_rsp_rdy = rr[1];
            s_req_rdy = ($urandom % 4 != 0);
            s_rsp_vld = sv; s_rsp_data = sdat; s_rsp_ok = sok;
            #1;

            if (held >= 0) g = held;
            else if (mv[0] && mv[1]) g = pref;
            else if (mv[0]) g = 0;
            else if (mv[1]) g = 1;
            else g = -1;
            full = (ost.size() == int'(DEPTH));
            exp_svld = (g >= 0) && !full;
            if (s_req_vld !== exp_svld) begin
                errors++;
                $display("FAIL rand_s_req_vld cyc=%0d: got %b expected %b", c, s_req_vld, exp_svld);
            end
            checks++;
            if (exp_svld) begin
                if ({s_req_cmd, s_req_addr, s_req_data, s_req_strb} !== {mc[g], ma[g], md[g], ms[g]}) begin
                    errors++;
                    $display("FAIL rand_s_req_pkt cyc=%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             c, s_req_addr, s_req_data, ma[g], md[g]);
                end
                checks++;
            end
            for (int i = 0; i < 2; i++) begin
                if (mv[i]) begin
                    obs_rdy = (i == 0) ? m0_req_rdy : m1_req_rdy;
                    if (obs_rdy !== (exp_svld && g == i && s_req_rdy)) begin
                        errors++;
                        $display("FAIL rand_req_rdy cyc=%0d m%0d: got %b expected %b",
                                 c, i, obs_rdy, (exp_svld && g == i && s_req_rdy));
                    end
                    checks++;
                end
            end

            h = (ost.size() == 0) ? -1 : ost[0];
            exp_srr = (h >= 0) && rr[h];
            if (s_rsp_rdy !== exp_srr) begin
                errors++;
                $display("FAIL rand_s_rsp_rdy cyc=%0d: got %b expected %b", c, s_rsp_rdy, exp_srr);
            end
            checks++;
            if ({m0_rsp_vld, m1_rsp_vld} !== {sv && h == 0, sv && h == 1}) begin
                errors++;
                $display("FAIL rand_rsp_vld cyc=%0d: got %b expected %b",
                         c, {m0_rsp_vld, m1_rsp_vld}, {sv && h == 0, sv && h == 1});
            end
            checks++;

            req_hs = exp_svld && s_req_rdy;
            rsp_hs = sv && exp_srr;
            if (rsp_hs) begin
                exp_d  = (h == 0) ? eq0.pop_front() : eq1.pop_front();
                obs_d  = (h == 0) ? m0_rsp_data : m1_rsp_data;
                obs_ok = (h == 0) ? m0_rsp_ok : m1_rsp_ok;
                if (obs_d !== exp_d || obs_ok !== sok) begin
                    errors++;
                    $display("FAIL rand_rsp_data cyc=%0d m%0d: got %0h/%b expected %0h/%b",
                             c, h, obs_d, obs_ok, exp_d, sok);
                end
                checks++;
                void'(ost.pop_front());
                void'(slv.pop_front());
                sv = 0;
            end
            if (req_hs) begin
                ost.push_back(g);
                slv.push_back(md[g]);
                if (g == 0) eq0.push_back(md[g]);
                else eq1.push_back(md[g]);
                mv[g] = 0;
                held = -1;
`ifndef BUS_ARB_FIXED_PRIO_EN
                pref = 1 - g;
`endif
            end else if (exp_svld) begin
                held = g;
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_full();
        test_rsp_route();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
